// File: rtl/video_pkg.sv
// Shared video definitions: default geometry, pixel and stage types,
// and the timing constants also used by the VGA generator.
package video_pkg;

  localparam int HDISP_DEF = 800;
  localparam int VDISP_DEF = 480;

  localparam int HFP    = 40;
  localparam int HPULSE = 48;
  localparam int HBP    = 40;
  localparam int VFP    = 13;
  localparam int VPULSE = 3;
  localparam int VBP    = 29;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    VSYNC    = 2'd1,
    FRAME    = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    rgb_t rgb;
  } vid_s1_t;

endpackage

// File: rtl/video_rx_geom.sv
// x/y position counters for video_rx with saturation at HDISP/VDISP
// and the active-run / line-count geometry checks.
module video_rx_geom
  import video_pkg::*;
#(
  parameter int HDISP = HDISP_DEF,
  parameter int VDISP = VDISP_DEF,
  localparam int XCW = $clog2(HDISP + 1),
  localparam int YCW = $clog2(VDISP + 1)
) (
  input  logic           pixel_clk,
  input  logic           pixel_rst,
  input  logic           clear,
  input  logic           en,
  input  logic           active,
  input  logic           run_end,
  output logic [XCW-1:0] x,
  output logic [YCW-1:0] y,
  output logic           in_range,
  output logic           line_bad,
  output logic           count_bad,
  output logic           runs_bad
);

  localparam logic [XCW-1:0] XMAX = XCW'(HDISP);
  localparam logic [YCW-1:0] YMAX = YCW'(VDISP);

  // Overflow flags remember a run or frame that went past the saturated limit
  logic x_ovf;
  logic y_ovf;

  assign in_range  = (x < XMAX) && (y < YMAX);
  assign line_bad  = en && run_end && (x_ovf || (x != XMAX));
  assign count_bad = y_ovf || (y != YMAX);

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      x        <= '0;
      y        <= '0;
      x_ovf    <= 1'b0;
      y_ovf    <= 1'b0;
      runs_bad <= 1'b0;
    end else if (clear) begin
      x        <= '0;
      y        <= '0;
      x_ovf    <= 1'b0;
      y_ovf    <= 1'b0;
      runs_bad <= 1'b0;
    end else if (en) begin
      if (run_end) begin
        x     <= '0;
        x_ovf <= 1'b0;
        if (y == YMAX) y_ovf <= 1'b1;
        else           y     <= y + 1'b1;
        if (line_bad) runs_bad <= 1'b1;
      end else if (active) begin
        if (x == XMAX) x_ovf <= 1'b1;
        else           x     <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_rx.sv
// Video receiver: registers the generator bus, rebuilds pixel coordinates and
// checks geometry. Optional frame_sum output under VIDEO_RX_CHECKSUM_EN.
module video_rx
  import video_pkg::*;
#(
  parameter int HDISP = HDISP_DEF,
  parameter int VDISP = VDISP_DEF,
  localparam int XW  = $clog2(HDISP),
  localparam int YW  = $clog2(VDISP),
  localparam int XCW = $clog2(HDISP + 1),
  localparam int YCW = $clog2(VDISP + 1)
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          vid_hs,
  input  logic          vid_vs,
  input  logic          vid_blank,
  input  logic [23:0]   vid_rgb,
  output logic          pix_valid,
  output logic [23:0]   pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          locked,
  output logic          err_line,
  output logic          err_frame,
  output logic [15:0]   frame_cnt
`ifdef VIDEO_RX_CHECKSUM_EN
  ,
  output logic [31:0]   frame_sum
`endif
);

  localparam logic [XCW-1:0] XLAST = XCW'(HDISP - 1);

  vid_s1_t   s1;
  logic      vs_d;
  logic      blank_d;
  rx_state_t state;
  logic      hs_unused;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      s1      <= '0;
      vs_d    <= 1'b0;
      blank_d <= 1'b0;
    end else begin
      s1      <= '{hs: vid_hs, vs: vid_vs, blank: vid_blank, rgb: vid_rgb};
      vs_d    <= s1.vs;
      blank_d <= s1.blank;
    end
  end

  // Line boundaries come from blank alone; hs is carried but never checked
  assign hs_unused = s1.hs;

  logic vs_fall;
  logic run_end;
  logic in_frame;
  logic frame_end;

  assign vs_fall   = !s1.vs && vs_d;
  assign run_end   = blank_d && !s1.blank;
  assign in_frame  = (state == FRAME);
  assign frame_end = in_frame && vs_fall;

  logic [XCW-1:0] x;
  logic [YCW-1:0] y;
  logic           in_range;
  logic           line_bad;
  logic           count_bad;
  logic           runs_bad;

  video_rx_geom #(
    .HDISP (HDISP),
    .VDISP (VDISP)
  ) u_geom (
    .pixel_clk (pixel_clk),
    .pixel_rst (pixel_rst),
    .clear     ((state == VSYNC) && s1.vs),
    .en        (in_frame),
    .active    (s1.blank),
    .run_end   (run_end),
    .x         (x),
    .y         (y),
    .in_range  (in_range),
    .line_bad  (line_bad),
    .count_bad (count_bad),
    .runs_bad  (runs_bad)
  );

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state <= UNLOCKED;
    end else begin
      unique case (1'b1)
        state == UNLOCKED: if (vs_fall) state <= VSYNC;
        state == VSYNC:    if (s1.vs)   state <= FRAME;
        state == FRAME:    if (vs_fall) state <= VSYNC;
        default:           state <= UNLOCKED;
      endcase
    end
  end

  logic pv;
  logic sof_n;
  logic err_l;
  logic err_f;
  logic good;
  logic good_run;

  assign pv    = in_frame && s1.blank && in_range;
  assign sof_n = pv && (x == '0) && (y == '0);
  assign err_l = line_bad || (frame_end && s1.blank);
  assign err_f = frame_end && (count_bad || s1.blank);
  assign good  = frame_end && !err_f && !err_l && !runs_bad;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
      locked    <= 1'b0;
      good_run  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      pix_valid <= pv;
      pix_sof   <= sof_n;
      pix_eol   <= pv && (x == XLAST);
      if (pv) begin
        pix_data <= s1.rgb;
        pix_x    <= x[XW-1:0];
        pix_y    <= y[YW-1:0];
      end
      err_line  <= err_l;
      err_frame <= err_f;
      if (err_l || err_f) begin
        locked   <= 1'b0;
        good_run <= 1'b0;
      end else if (good) begin
        if (good_run) locked <= 1'b1;
        good_run  <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (frame_end) begin
        good_run <= 1'b0;
      end
    end
  end

`ifdef VIDEO_RX_CHECKSUM_EN
  logic [31:0] sum_acc;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else begin
      if (pv) sum_acc <= (sof_n ? 32'd0 : sum_acc) + {8'h00, s1.rgb};
      if (good) frame_sum <= sum_acc;
    end
  end
`endif

endmodule
